sm_dma: RTL and testbench
=========================

# sm_dma

Block-copy engine that acts as the initiator on one port of the dual-port data RAM. Software or a testbench writes a source address, destination address and word count, then pulses `start`. The engine copies the words in ascending address order through a single RAM port, using the read/write semantics of that port. It sits beside the CPU; its memory port connects to RAM port b, and the CPU keeps port a.

## Interface
Parameters:
- `LEN_W`, default 16: width of the word-count input. The maximum transfer is 2^LEN_W − 1 words.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  single-cycle request; accepted only in IDLE.
- `src`  in  32  source byte address; bits [1:0] are ignored.
- `dst`  in  32  destination byte address; bits [1:0] are ignored.
- `len`  in  LEN_W  transfer length in 32-bit words.
- `busy`  out  1  high from the cycle after acceptance until the DONE cycle, exclusive.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `mem_a`  out  32  RAM byte address.
- `mem_we`  out  1  RAM write enable.
- `mem_wd`  out  32  RAM write data.
- `mem_rd`  in  32  RAM read data; combinational from `mem_a`.
- `fill`  in  1  present only with SM_DMA_FILL_EN; sampled with `start`.
- `pattern`  in  32  present only with SM_DMA_FILL_EN; sampled with `start`.

## Operation
- States:
  - IDLE
  - READ
  - WRITE
  - FILL (present only with the macro)
  - DONE
- IDLE, `start`=1:
  - Latch the source pointer, destination pointer and count, with pointer bits [1:0] forced to 0.
  - If `len`=0, go to DONE.
  - Otherwise go to READ, or to FILL when `fill`=1.
- READ:
  - `mem_a`=src_ptr, `mem_we`=0.
  - At the clock edge, `mem_rd` is captured into data_q.
  - Next state is WRITE.
- WRITE:
  - `mem_a`=dst_ptr, `mem_we`=1, `mem_wd`=data_q.
  - At the clock edge: src_ptr += 4, dst_ptr += 4, count −= 1.
  - Next state is DONE if count was 1, otherwise READ.
- FILL:
  - `mem_a`=dst_ptr, `mem_we`=1, `mem_wd`=pattern_q.
  - At the clock edge: dst_ptr += 4, count −= 1.
  - Next state is DONE if count was 1, otherwise FILL.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. It is not queued and does not alter the latched operands.
- Pointers wrap modulo 2^32.
- Overlapping regions: the result is exactly a sequential ascending word-by-word copy. Example: dst = src+4 replicates the first word across the region.
- Outputs in IDLE and DONE:
  - `mem_we`=0.
  - `mem_a`=0.
  - `mem_wd`=0.
- `mem_we` is never high outside WRITE or FILL.

## Timing
- Reset values:
  - state=IDLE
  - `busy`=0
  - `done`=0
  - `mem_we`=0
  - `mem_a`=0
  - `mem_wd`=0
  - internal registers all 0
- Reset mid-transfer: the engine is in IDLE in the cycle after the reset edge.
  - `mem_we` is low from that cycle onward.
  - Words already written stay written.
  - No `done` pulse is issued.
- Copy of N≥1 words, with acceptance at edge 0:
  - READ is in cycle 1 and WRITE in cycle 2 for word 0.
  - Word i is written in cycle 2i+2.
  - `done` is high in cycle 2N+1, and IDLE returns in cycle 2N+2.
- Fill of N words:
  - Word i is written in cycle i+1.
  - `done` is high in cycle N+1.
- `len`=0: `done` is high in cycle 1 with no write.
- A new `start` is accepted in the first IDLE cycle after DONE. Back-to-back transfers therefore have one idle cycle between them.
- All outputs are decoded from registered state; there is no combinational path from `start` to the memory port.

## Configuration
- `SM_DMA_FILL_EN` defined:
  - The `fill` and `pattern` ports and the FILL state exist.
  - `fill`=1 with `start` writes `pattern` to `len` words at `dst`, one word per cycle.
  - `src` is ignored in fill mode.
- `SM_DMA_FILL_EN` undefined:
  - The `fill` and `pattern` ports and the FILL state are absent.
  - Every transfer is a copy.

## Structure
- Header `sm_dma_defs.vh` holds:
  - the state encodings SM_DMA_IDLE, SM_DMA_READ, SM_DMA_WRITE, SM_DMA_FILL and SM_DMA_DONE, 3 bits each;
  - the word-step constant SM_DMA_STEP = 4.
- One sub-module is natural: `sm_dma_ptr`, the pointer/count datapath.
  - Inputs: load, src, dst, len, advance_src, advance_dst.
  - Outputs: src_ptr, dst_ptr, last (count==1).
- The FSM and output decode stay in `sm_dma`.

## Test plan
- Copy:
  - Preload RAM words 0..3 with 0x11, 0x22, 0x33, 0x44.
  - Pulse start with src=0x0, dst=0x40, len=4.
  - Expect words 16..19 = 0x11..0x44.
  - Expect `done` exactly in cycle 9.
  - Expect `busy` high in cycles 1–8.
- Zero length: len=0, dst=0x40. Expect `done` in cycle 1, no `mem_we` pulse, RAM unchanged.
- Ignored start: pulse start with src=0x80 while a len=4 copy is in progress. Expect only the original transfer's writes and a single `done`.
- Reset mid-transfer, len=8:
  - Assert `rst` in cycle 5.
  - Expect only words 0 and 1 written at dst and no `done`.
  - Expect `mem_we`=0 from cycle 6.
  - A subsequent start works normally.
- Overlap and alignment: src=0x3 (treated as 0x0), dst=0x4, len=3, word0=0xAB. Expect words 1..3 = 0xAB.
- Fill (with SM_DMA_FILL_EN): fill=1, pattern=0xDEADBEEF, dst=0x20, len=5. Expect words 8..12 = 0xDEADBEEF and `done` in cycle 6.

Source files
------------

// File: rtl/sm_dma_pkg.sv
// Shared encodings for the sm_dma block-copy engine: FSM state codes and word step.
// The FILL code is only reachable when SM_DMA_FILL_EN is defined.
package sm_dma_pkg;

    typedef enum logic [2:0] {
        SM_DMA_IDLE  = 3'd0,
        SM_DMA_READ  = 3'd1,
        SM_DMA_WRITE = 3'd2,
        SM_DMA_FILL  = 3'd3,
        SM_DMA_DONE  = 3'd4
    } sm_dma_state_e;

    localparam logic [31:0] SM_DMA_STEP = 32'd4;

endpackage

// File: rtl/sm_dma_ptr.sv
// Pointer/count datapath for sm_dma: word-aligned source/destination pointers
// and the remaining word count, with a flag marking the final word.
module sm_dma_ptr
    import sm_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    input  logic             advance_src,
    input  logic             advance_dst,
    output logic [31:0]      src_ptr,
    output logic [31:0]      dst_ptr,
    output logic             last
);

    logic [LEN_W-1:0] count_q;
    // Byte-lane bits of the operands are dropped on load.
    logic             unused_lanes;

    assign unused_lanes = &{1'b0, src[1:0], dst[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            src_ptr <= '0;
            dst_ptr <= '0;
            count_q <= '0;
        end else if (load) begin
            src_ptr <= {src[31:2], 2'b00};
            dst_ptr <= {dst[31:2], 2'b00};
            count_q <= len;
        end else begin
            if (advance_src) begin
                src_ptr <= src_ptr + SM_DMA_STEP;
            end
            // Every written word advances the destination and consumes one count.
            if (advance_dst) begin
                dst_ptr <= dst_ptr + SM_DMA_STEP;
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign last = (count_q == {{(LEN_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/sm_dma.sv
// sm_dma: block-copy engine driving one RAM port; copies words in ascending order.
// Optional SM_DMA_FILL_EN adds a one-word-per-cycle pattern fill mode.
module sm_dma
    import sm_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src,
    input  logic [31:0]      dst,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [31:0]      mem_a,
    output logic             mem_we,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd
`ifdef SM_DMA_FILL_EN
    ,
    input  logic             fill,
    input  logic [31:0]      pattern
`endif
);

    sm_dma_state_e state_q, state_d;
    logic          load, advance_src, advance_dst, last;
    logic [31:0]   src_ptr, dst_ptr, data_q;

    sm_dma_ptr #(.LEN_W(LEN_W)) u_ptr (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .src         (src),
        .dst         (dst),
        .len         (len),
        .advance_src (advance_src),
        .advance_dst (advance_dst),
        .src_ptr     (src_ptr),
        .dst_ptr     (dst_ptr),
        .last        (last)
    );

`ifdef SM_DMA_FILL_EN
    logic [31:0] pattern_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= '0;
        end else if (state_q == SM_DMA_IDLE && start) begin
            pattern_q <= pattern;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SM_DMA_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SM_DMA_READ) begin
                data_q <= mem_rd;
            end
        end
    end

    // Memory port is decoded from registered state only; start never reaches it.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        advance_src = 1'b0;
        advance_dst = 1'b0;
        mem_a       = '0;
        mem_we      = 1'b0;
        mem_wd      = '0;
        case (state_q)
            SM_DMA_IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (len == '0) begin
                        state_d = SM_DMA_DONE;
                    end else begin
`ifdef SM_DMA_FILL_EN
                        state_d = fill ? SM_DMA_FILL : SM_DMA_READ;
`else
                        state_d = SM_DMA_READ;
`endif
                    end
                end
            end
            SM_DMA_READ: begin
                mem_a   = src_ptr;
                state_d = SM_DMA_WRITE;
            end
            SM_DMA_WRITE: begin
                mem_a       = dst_ptr;
                mem_we      = 1'b1;
                mem_wd      = data_q;
                advance_src = 1'b1;
                advance_dst = 1'b1;
                state_d     = last ? SM_DMA_DONE : SM_DMA_READ;
            end
`ifdef SM_DMA_FILL_EN
            SM_DMA_FILL: begin
                mem_a       = dst_ptr;
                mem_we      = 1'b1;
                mem_wd      = pattern_q;
                advance_dst = 1'b1;
                state_d     = last ? SM_DMA_DONE : SM_DMA_FILL;
            end
`endif
            SM_DMA_DONE: begin
                state_d = SM_DMA_IDLE;
            end
            default: begin
                state_d = SM_DMA_IDLE;
            end
        endcase
    end

    assign busy = (state_q == SM_DMA_READ) || (state_q == SM_DMA_WRITE)
`ifdef SM_DMA_FILL_EN
               || (state_q == SM_DMA_FILL)
`endif
               ;
    assign done = (state_q == SM_DMA_DONE);

endmodule

// File: tb/tb_sm_dma.sv
// Directed bench for sm_dma with a behavioural RAM on the engine's port.
// Define SM_DMA_FILL_EN to also exercise the pattern fill mode.
module tb_sm_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len = '0;
    logic        busy, done, mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
`ifdef SM_DMA_FILL_EN
    logic        fill = 1'b0;
    logic [31:0] pattern = '0;
`endif

    logic [31:0] ram [256];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sm_dma #(.LEN_W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .mem_a   (mem_a),
        .mem_we  (mem_we),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd)
`ifdef SM_DMA_FILL_EN
        ,
        .fill    (fill),
        .pattern (pattern)
`endif
    );

    assign mem_rd = ram[mem_a[9:2]];

    always @(posedge clk) begin
        if (mem_we) ram[mem_a[9:2]] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues start in the current cycle (cycle 0) and runs ncyc cycles, recording events.
    task automatic xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                        input int ncyc, input int poke_cyc, input int rst_cyc,
                        output int done_cyc, output int n_done, output int n_we,
                        output int n_busy, output int busy_first, output int busy_last,
                        output int we_late, output logic [31:0] a1, output logic [31:0] a2,
                        output logic [31:0] wd2);
        src = s; dst = d; len = l; start = 1'b1;
        done_cyc = -1; n_done = 0; n_we = 0; n_busy = 0;
        busy_first = -1; busy_last = -1; we_late = 0;
        a1 = 'x; a2 = 'x; wd2 = 'x;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            rst   = 1'b0;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (busy) begin
                n_busy++;
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (mem_we) begin
                n_we++;
                if (rst_cyc > 0 && c > rst_cyc) we_late++;
            end
            if (c == 1) a1 = mem_a;
            if (c == 2) begin a2 = mem_a; wd2 = mem_wd; end
            if (c == poke_cyc) begin
                start = 1'b1; src = 32'h80; dst = 32'h100; len = 16'd4;
            end
            if (c == rst_cyc) rst = 1'b1;
        end
    endtask

    initial begin
        int dc, nd, nw, nb, bf, bl, wl;
        logic [31:0] a1, a2, wd2;

        for (int i = 0; i < 256; i++) ram[i] = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_a", mem_a, 32'd0);
        check("rst_wd", mem_wd, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic copy of 4 words: 0x0 -> 0x40
        ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;
        xfer(32'h0, 32'h40, 16'd4, 11, 0, 0, dc, nd, nw, nb, bf, bl, wl, a1, a2, wd2);
        check("copy_done_cyc", dc, 32'd9);
        check("copy_done_cnt", nd, 32'd1);
        check("copy_we_cnt", nw, 32'd4);
        check("copy_busy_first", bf, 32'd1);
        check("copy_busy_last", bl, 32'd8);
        check("copy_busy_cnt", nb, 32'd8);
        check("copy_read_addr", a1, 32'h0);
        check("copy_write_addr", a2, 32'h40);
        check("copy_write_data", wd2, 32'h11);
        check("copy_w16", ram[16], 32'h11);
        check("copy_w17", ram[17], 32'h22);
        check("copy_w18", ram[18], 32'h33);
        check("copy_w19", ram[19], 32'h44);
        check("copy_w20", ram[20], 32'h0);
        check("idle_a", mem_a, 32'h0);

        // Zero length: done in cycle 1, nothing written
        xfer(32'h0, 32'h40, 16'd0, 4, 0, 0, dc, nd, nw, nb, bf, bl, wl, a1, a2, wd2);
        check("zero_done_cyc", dc, 32'd1);
        check("zero_done_cnt", nd, 32'd1);
        check("zero_we_cnt", nw, 32'd0);
        check("zero_busy_cnt", nb, 32'd0);
        check("zero_w16", ram[16], 32'h11);

        // Start pulsed mid-transfer must be ignored
        xfer(32'h0, 32'h60, 16'd4, 14, 3, 0, dc, nd, nw, nb, bf, bl, wl, a1, a2, wd2);
        check("ign_done_cyc", dc, 32'd9);
        check("ign_done_cnt", nd, 32'd1);
        check("ign_we_cnt", nw, 32'd4);
        check("ign_w24", ram[24], 32'h11);
        check("ign_w27", ram[27], 32'h44);
        check("ign_w64", ram[64], 32'h0);

        // Reset mid-transfer of 8 words: asserted in cycle 5
        ram[4] = 32'h55; ram[5] = 32'h66; ram[6] = 32'h77; ram[7] = 32'h88;
        xfer(32'h0, 32'hA0, 16'd8, 12, 0, 5, dc, nd, nw, nb, bf, bl, wl, a1, a2, wd2);
        check("rmid_done_cnt", nd, 32'd0);
        check("rmid_we_cnt", nw, 32'd2);
        check("rmid_we_late", wl, 32'd0);
        check("rmid_w40", ram[40], 32'h11);
        check("rmid_w41", ram[41], 32'h22);
        check("rmid_w42", ram[42], 32'h0);
        check("rmid_w47", ram[47], 32'h0);
        xfer(32'h10, 32'hC0, 16'd2, 7, 0, 0, dc, nd, nw, nb, bf, bl, wl, a1, a2, wd2);
        check("after_rst_done_cyc", dc, 32'd5);
        check("after_rst_w48", ram[48], 32'h55);
        check("after_rst_w49", ram[49], 32'h66);

        // Overlap and alignment: src 0x3 acts as 0x0, dst = src+4 replicates word 0
        ram[0] = 32'hAB; ram[1] = 32'h1; ram[2] = 32'h2; ram[3] = 32'h3; ram[4] = 32'h4;
        xfer(32'h3, 32'h4, 16'd3, 9, 0, 0, dc, nd, nw, nb, bf, bl, wl, a1, a2, wd2);
        check("ovl_done_cyc", dc, 32'd7);
        check("ovl_w1", ram[1], 32'hAB);
        check("ovl_w2", ram[2], 32'hAB);
        check("ovl_w3", ram[3], 32'hAB);
        check("ovl_w4", ram[4], 32'h4);

`ifdef SM_DMA_FILL_EN
        // Pattern fill of 5 words at 0x20
        fill = 1'b1; pattern = 32'hDEADBEEF;
        xfer(32'h0, 32'h20, 16'd5, 8, 0, 0, dc, nd, nw, nb, bf, bl, wl, a1, a2, wd2);
        fill = 1'b0;
        check("fill_done_cyc", dc, 32'd6);
        check("fill_we_cnt", nw, 32'd5);
        check("fill_first_addr", a1, 32'h20);
        check("fill_w8", ram[8], 32'hDEADBEEF);
        check("fill_w12", ram[12], 32'hDEADBEEF);
        check("fill_w13", ram[13], 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
